arp_send: RTL and testbench

Transmit-side ARP responder for the UDP/Ethernet stack. Takes a reply request plus the remote IP/MAC pair from the ARP receive path and serialises a complete Ethernet II ARP reply frame, one byte per beat, onto an 8-bit AXI-stream toward the MAC transmit FIFO. Sits beside `arp_recv`, consuming its `arp_reply_out`, `remote_ip_addr_out` and `remote_mac_addr_out`, and returning `reply_ready` and `arp_reply_ack`.

---
 rtl/eth_pkg.sv | 21 ++
 rtl/arp_send_if.sv | 12 +
 rtl/arp_send.sv | 132 +++++++++++++
 tb/tb_arp_send.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and the ARP transmit FSM state type,
// used by both the ARP receive and transmit paths.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  ARP_HLEN         = 8'd6;
    localparam logic [7:0]  ARP_PLEN         = 8'd4;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;

    localparam int unsigned ARP_FRAME_LEN = 42;
    localparam int unsigned ETH_MIN_FRAME = 60;

    typedef enum logic {
        ARP_TX_IDLE = 1'b0,
        ARP_TX_SEND = 1'b1
    } arp_tx_state_e;

endpackage

// File: rtl/arp_send_if.sv
// 8-bit AXI-stream byte channel carrying the ARP reply frame toward the MAC.
interface arp_send_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/arp_send.sv
// ARP reply transmitter: captures a reply request and serialises the
// Ethernet II ARP reply frame one byte per beat onto an AXI stream.
module arp_send
    import eth_pkg::*;
#(
    parameter bit PAD_TO_MIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] mac_addr,
    input  logic [31:0] local_ip_addr,
    input  logic        arp_reply_in,
    input  logic [31:0] remote_ip_addr_in,
    input  logic [47:0] remote_mac_addr_in,
    output logic        reply_ready_out,
    output logic        arp_reply_ack_out,
    arp_send_if.master  axis
);

    localparam int unsigned FRAME_LEN = PAD_TO_MIN ? ETH_MIN_FRAME : ARP_FRAME_LEN;
    localparam logic [5:0]  LAST_IDX  = 6'(FRAME_LEN - 1);

    // Bytes past the 42-byte ARP body are the zero padding.
    function automatic logic [7:0] frame_byte(
        input logic [47:0] sha,
        input logic [31:0] spa,
        input logic [47:0] tha,
        input logic [31:0] tpa,
        input logic [5:0]  idx
    );
        logic [ARP_FRAME_LEN*8-1:0] body;
        int unsigned                pos;
        body = {tha, sha, ETHERTYPE_ARP, ARP_HTYPE_ETH, ARP_PTYPE_IPV4,
                ARP_HLEN, ARP_PLEN, ARP_OPER_REPLY, sha, spa, tha, tpa};
        if (idx < 6'(ARP_FRAME_LEN)) begin
            pos = (ARP_FRAME_LEN - 1) - {26'd0, idx};
            return body[8*pos +: 8];
        end
        return 8'h00;
    endfunction

    arp_tx_state_e state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [47:0]   sha_q, sha_d;
    logic [31:0]   spa_q, spa_d;
    logic [47:0]   tha_q, tha_d;
    logic [31:0]   tpa_q, tpa_d;
    logic [7:0]    tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          ack_q, ack_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sha_d    = sha_q;
        spa_d    = spa_q;
        tha_d    = tha_q;
        tpa_d    = tpa_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        ack_d    = 1'b0;
        unique case (state_q)
            ARP_TX_IDLE: begin
                if (arp_reply_in) begin
                    sha_d    = mac_addr;
                    spa_d    = local_ip_addr;
                    tha_d    = remote_mac_addr_in;
                    tpa_d    = remote_ip_addr_in;
                    idx_d    = '0;
                    state_d  = ARP_TX_SEND;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    ack_d    = 1'b1;
                    // First byte comes straight from the inputs being captured.
                    tdata_d  = frame_byte(mac_addr, local_ip_addr, remote_mac_addr_in,
                                          remote_ip_addr_in, 6'd0);
                end
            end
            ARP_TX_SEND: begin
                if (tvalid_q && axis.tready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = ARP_TX_IDLE;
                        idx_d    = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = '0;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        tdata_d = frame_byte(sha_q, spa_q, tha_q, tpa_q, idx_q + 6'd1);
                        tlast_d = ((idx_q + 6'd1) == LAST_IDX);
                    end
                end
            end
            default: state_d = ARP_TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARP_TX_IDLE;
            idx_q    <= '0;
            sha_q    <= '0;
            spa_q    <= '0;
            tha_q    <= '0;
            tpa_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sha_q    <= sha_d;
            spa_q    <= spa_d;
            tha_q    <= tha_d;
            tpa_q    <= tpa_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            ack_q    <= ack_d;
        end
    end

    assign axis.tdata        = tdata_q;
    assign axis.tvalid       = tvalid_q;
    assign axis.tlast        = tlast_q;
    assign arp_reply_ack_out = ack_q;
    assign reply_ready_out   = (state_q == ARP_TX_IDLE);

endmodule

// File: tb/tb_arp_send.sv
// Directed scoreboard bench for arp_send: padded and bare frames, stalls,
// input changes in flight, back-to-back requests and mid-frame reset.
module tb_arp_send;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [47:0] mac_addr, rmac;
    logic [31:0] lip, rip;
    logic        req_a, req_b;
    logic        rdy_a, rdy_b, ack_a, ack_b;

    arp_send_if ifa ();
    arp_send_if ifb ();

    arp_send #(.PAD_TO_MIN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .mac_addr(mac_addr), .local_ip_addr(lip),
        .arp_reply_in(req_a), .remote_ip_addr_in(rip), .remote_mac_addr_in(rmac),
        .reply_ready_out(rdy_a), .arp_reply_ack_out(ack_a), .axis(ifa)
    );

    arp_send #(.PAD_TO_MIN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .mac_addr(mac_addr), .local_ip_addr(lip),
        .arp_reply_in(req_b), .remote_ip_addr_in(rip), .remote_mac_addr_in(rmac),
        .reply_ready_out(rdy_b), .arp_reply_ack_out(ack_b), .axis(ifb)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    logic [7:0]  q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic       cur_v  (input bit s); return s ? ifb.tvalid : ifa.tvalid; endfunction
    function automatic logic       cur_l  (input bit s); return s ? ifb.tlast  : ifa.tlast;  endfunction
    function automatic logic [7:0] cur_d  (input bit s); return s ? ifb.tdata  : ifa.tdata;  endfunction
    function automatic logic       cur_ack(input bit s); return s ? ack_b : ack_a; endfunction
    function automatic logic       cur_rdy(input bit s); return s ? rdy_b : rdy_a; endfunction

    task automatic set_ready(input bit s, input logic r);
        if (s) ifb.tready = r;
        else   ifa.tready = r;
    endtask

    task automatic set_req(input bit s, input logic r);
        if (s) req_b = r;
        else   req_a = r;
    endtask

    task automatic push_frame(input int n);
        logic [7:0] hdr [10];
        hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
        for (int i = 0; i < 6; i++)  q.push_back(rmac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++)  q.push_back(mac_addr[47-8*i -: 8]);
        for (int i = 0; i < 10; i++) q.push_back(hdr[i]);
        for (int i = 0; i < 6; i++)  q.push_back(mac_addr[47-8*i -: 8]);
        for (int i = 0; i < 4; i++)  q.push_back(lip[31-8*i -: 8]);
        for (int i = 0; i < 6; i++)  q.push_back(rmac[47-8*i -: 8]);
        for (int i = 0; i < 4; i++)  q.push_back(rip[31-8*i -: 8]);
        for (int i = 42; i < n; i++) q.push_back(8'h00);
    endtask

    task automatic check_first_beat(input bit s);
        chk("ack_pulse", cur_ack(s), 1'b1);
        chk("first_tvalid", cur_v(s), 1'b1);
        chk("ready_low_at_start", cur_rdy(s), 1'b0);
        chk("first_tdata", cur_d(s), rmac[47:40]);
    endtask

    task automatic start_frame(input bit s);
        set_req(s, 1'b1);
        @(posedge clk); #1;
        check_first_beat(s);
    endtask

    task automatic stream(input bit s, input int n, input bit rnd, input bit chg_ip);
        int beat = 0;
        int cyc  = 0;
        logic v, l, r;
        logic [7:0] d, e;
        while (beat < n && cyc < 1000) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            set_ready(s, r);
            if (chg_ip && beat == 3) rip = 32'h0A00_0005;
            v = cur_v(s); d = cur_d(s); l = cur_l(s);
            chk("tvalid_in_frame", v, 1'b1);
            chk("ready_low_in_frame", cur_rdy(s), 1'b0);
            @(posedge clk); #1;
            cyc++;
            if (v && r) begin
                e = q.pop_front();
                chk("tdata", d, e);
                chk("tlast", l, (beat == n - 1));
                beat++;
            end else begin
                chk("hold_tdata", cur_d(s), d);
                chk("hold_tvalid", cur_v(s), v);
                chk("hold_tlast", cur_l(s), l);
            end
            if (beat < n) chk("ack_low", cur_ack(s), 1'b0);
        end
        chk("frame_complete", beat, n);
        chk("tvalid_after_frame", cur_v(s), 1'b0);
        chk("ready_after_frame", cur_rdy(s), 1'b1);
        set_ready(s, 1'b1);
    endtask

    initial begin
        reset      = 1'b0;
        req_a      = 1'b0;
        req_b      = 1'b0;
        ifa.tready = 1'b1;
        ifb.tready = 1'b1;
        mac_addr   = 48'h000A_3500_0102;
        lip        = 32'hC0A8_010A;
        rmac       = 48'h3C97_0E11_2233;
        rip        = 32'hC0A8_0101;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", ifa.tvalid, 1'b0);
        chk("rst_tlast", ifa.tlast, 1'b0);
        chk("rst_tdata", ifa.tdata, 8'h00);
        chk("rst_ack", ack_a, 1'b0);
        chk("rst_ready", rdy_a, 1'b1);
        chk("rst_tvalid_b", ifb.tvalid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Padded frame, tready held high.
        push_frame(60);
        start_frame(1'b0);
        req_a = 1'b0;
        stream(1'b0, 60, 1'b0, 1'b0);

        // Bare 42-byte frame.
        push_frame(42);
        start_frame(1'b1);
        req_b = 1'b0;
        stream(1'b1, 42, 1'b0, 1'b0);

        // Random back-pressure.
        push_frame(60);
        start_frame(1'b0);
        req_a = 1'b0;
        stream(1'b0, 60, 1'b1, 1'b0);
        push_frame(42);
        start_frame(1'b1);
        req_b = 1'b0;
        stream(1'b1, 42, 1'b1, 1'b0);

        // Remote IP changes while the frame is in flight.
        push_frame(60);
        start_frame(1'b0);
        req_a = 1'b0;
        stream(1'b0, 60, 1'b0, 1'b1);
        rip = 32'hC0A8_0101;

        // Request held high: second frame after exactly one idle cycle.
        push_frame(60);
        start_frame(1'b0);
        stream(1'b0, 60, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_first_beat(1'b0);
        req_a = 1'b0;
        push_frame(60);
        stream(1'b0, 60, 1'b0, 1'b0);

        // Reset asserted while beat 20 is on the bus.
        start_frame(1'b0);
        req_a = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("tvalid_before_reset", ifa.tvalid, 1'b1);
        reset = 1'b0;
        #1;
        chk("async_rst_tvalid", ifa.tvalid, 1'b0);
        chk("async_rst_tlast", ifa.tlast, 1'b0);
        chk("async_rst_tdata", ifa.tdata, 8'h00);
        chk("async_rst_ready", rdy_a, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("post_reset_idle_tvalid", ifa.tvalid, 1'b0);
            chk("post_reset_idle_ready", rdy_a, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
